collision_scheduler: RTL and testbench

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/collision_scheduler_pkg.sv | 23 ++
 rtl/collision_scheduler_abs.sv | 18 +
 rtl/collision_scheduler.sv | 140 ++++++++++++++
 tb/tb_collision_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_scheduler_pkg.sv
// Shared constants and types for the collision scheduler and its bench.
// Holds the default object count, the index-width helper and the FSM encoding.
// No logic lives here.
package collision_scheduler_pkg;

  // Default number of tracked objects.
  localparam int N_OBJ_DEF = 10;

  // Width needed to index n objects.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(N_OBJ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_X = 2'd1,
    ST_CALC_Y = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/collision_scheduler_abs.sv
// Absolute difference of two bytes, squared.
// Purely combinational: this is the single shared 8x8 multiplier.
// No handshake; the caller muxes operands and registers the result.
module abs_diff_sq (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] sq
);

  logic [7:0] d;

  // |a-b| stays within 8 bits, so the square fits exactly in 16 bits.
  always_comb begin
    d  = (a >= b) ? (a - b) : (b - a);
    sq = {8'd0, d} * {8'd0, d};
  end

endmodule

// File: rtl/collision_scheduler.sv
// Sequential per-object squared-distance check against a radius threshold.
// Two cycles per object plus one DONE cycle; done pulses 21 cycles after start cycle (N_OBJ=10).
// start/clear are only honoured in IDLE; requests while busy are dropped.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int N_OBJ = N_OBJ_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [7:0]           self_x,
  input  logic [7:0]           self_y,
  input  logic [8*N_OBJ-1:0]   obj_x_flat,
  input  logic [8*N_OBJ-1:0]   obj_y_flat,
  input  logic [N_OBJ-1:0]     obj_valid,
  input  logic [N_OBJ-1:0]     touch_edge,
  input  logic [15:0]          radius_sq,
  output logic                 busy,
  output logic                 done,
  output logic [N_OBJ-1:0]     crash,
  output logic                 game_is_over
);

  localparam int IW = idx_width(N_OBJ);

  state_t state, state_nxt;

  logic [IW-1:0]      idx;
  logic [7:0]         self_x_q, self_y_q;
  logic [8*N_OBJ-1:0] obj_x_q, obj_y_q;
  logic [N_OBJ-1:0]   valid_q, touch_q;
  logic [15:0]        radius_q;
  logic [15:0]        dx2_q;

  logic [7:0]         op_a, op_b;
  logic [15:0]        sq;
  logic [16:0]        sum;
  logic               hit;
  logic               last;
  logic               accept;
  logic [N_OBJ-1:0]   crash_nxt;

  assign accept = (state == ST_IDLE) && start && !clear;
  assign last   = (idx == IW'(N_OBJ - 1));
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  // Steer the shared multiplier: x operands in CALC_X, y operands otherwise.
  always_comb begin
    op_a = self_x_q;
    op_b = obj_x_q[8*idx +: 8];
    if (state == ST_CALC_Y) begin
      op_a = self_y_q;
      op_b = obj_y_q[8*idx +: 8];
    end
  end

  abs_diff_sq u_abs_diff_sq (
    .a  (op_a),
    .b  (op_b),
    .sq (sq)
  );

  // 17-bit sum so two maximal squares (130050) never wrap; compare is inclusive.
  always_comb begin
    sum            = {1'b0, dx2_q} + {1'b0, sq};
    hit            = valid_q[idx] & (sum <= {1'b0, radius_q});
    crash_nxt      = crash;
    crash_nxt[idx] = hit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: fixed walk over every object, invalid ones included.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_CALC_X;
      ST_CALC_X: state_nxt = ST_CALC_Y;
      ST_CALC_Y: state_nxt = last ? ST_DONE : ST_CALC_X;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot, per-object results and the sticky game-over flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      crash        <= '0;
      game_is_over <= 1'b0;
      dx2_q        <= '0;
      self_x_q     <= '0;
      self_y_q     <= '0;
      obj_x_q      <= '0;
      obj_y_q      <= '0;
      valid_q      <= '0;
      touch_q      <= '0;
      radius_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            crash        <= '0;
            game_is_over <= 1'b0;
          end else if (start) begin
            self_x_q <= self_x;
            self_y_q <= self_y;
            obj_x_q  <= obj_x_flat;
            obj_y_q  <= obj_y_flat;
            valid_q  <= obj_valid;
            touch_q  <= touch_edge;
            radius_q <= radius_sq;
            crash    <= '0;
            idx      <= '0;
          end
        end
        ST_CALC_X: dx2_q <= sq;
        ST_CALC_Y: begin
          crash <= crash_nxt;
          if (last) begin
            idx <= '0;
            // Updated on entry to DONE so the flag is visible alongside done.
            if (|(crash_nxt | touch_q)) game_is_over <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: directed scans push expected results,
// a negedge monitor pops and compares whenever done is seen.
// Reset/clear behaviour is checked directly from the stimulus process.
module tb_collision_scheduler;
  import collision_scheduler_pkg::*;

  localparam int N = N_OBJ_DEF;
  localparam int LAT = 21;

  logic           clk = 1'b0;
  logic           reset, start, clear;
  logic [7:0]     self_x, self_y;
  logic [8*N-1:0] obj_x_flat, obj_y_flat;
  logic [N-1:0]   obj_valid, touch_edge;
  logic [15:0]    radius_sq;
  logic           busy, done;
  logic [N-1:0]   crash;
  logic           game_is_over;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] crash;
    logic         go;
    int           s;
  } exp_t;
  exp_t sb[$];

  collision_scheduler #(.N_OBJ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .self_x       (self_x),
    .self_y       (self_y),
    .obj_x_flat   (obj_x_flat),
    .obj_y_flat   (obj_y_flat),
    .obj_valid    (obj_valid),
    .touch_edge   (touch_edge),
    .radius_sq    (radius_sq),
    .busy         (busy),
    .done         (done),
    .crash        (crash),
    .game_is_over (game_is_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no scan pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("scan_crash", 32'(crash), 32'(e.crash));
        chk("scan_game_over", 32'(game_is_over), 32'(e.go));
        chk("scan_latency", 32'(cyc - e.s), 32'(LAT));
      end
    end
  end

  task automatic set_all(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < N; i++) begin
      obj_x_flat[8*i +: 8] = x;
      obj_y_flat[8*i +: 8] = y;
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] x, input logic [7:0] y);
    obj_x_flat[8*i +: 8] = x;
    obj_y_flat[8*i +: 8] = y;
  endtask

  task automatic base_setup();
    self_x = 8'd50; self_y = 8'd50;
    set_all(8'd0, 8'd0);
    obj_valid  = '1;
    touch_edge = '0;
    radius_sq  = 16'd100;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d scans pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_scan(input logic [N-1:0] ec, input logic eg);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.crash = ec; e.go = eg; e.s = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_game_over", 32'(game_is_over), 32'd0);
    chk("clear_crash", 32'(crash), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0;
    base_setup();
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_crash", 32'(crash), 32'd0);
    chk("reset_game_over", 32'(game_is_over), 32'd0);
    reset = 1'b0;

    // All objects far away: sum 5000 > 100.
    run_scan('0, 1'b0);
    // Object 3 at (53,54): sum 25.
    set_obj(3, 8'd53, 8'd54);
    run_scan(10'h008, 1'b1);
    do_clear();

    // Object 0 at (60,50): sum exactly 100, inclusive compare.
    set_obj(3, 8'd0, 8'd0);
    set_obj(0, 8'd60, 8'd50);
    run_scan(10'h001, 1'b1);
    do_clear();
    radius_sq = 16'd99;
    run_scan('0, 1'b0);

    // radius 0: only exact overlap (object 5) hits.
    radius_sq = 16'd0;
    set_obj(0, 8'd0, 8'd0);
    set_obj(5, 8'd50, 8'd50);
    run_scan(10'h020, 1'b1);
    do_clear();

    // Extremes: 130050 must not wrap; invalid object on top of self is ignored.
    self_x = 8'd0; self_y = 8'd0;
    set_all(8'd200, 8'd200);
    set_obj(0, 8'd255, 8'd255);
    set_obj(3, 8'd0, 8'd0);
    obj_valid = 10'h3F7;
    radius_sq = 16'hFFFF;
    run_scan('0, 1'b0);

    // Edge touch alone ends the game.
    base_setup();
    touch_edge = 10'h200;
    run_scan('0, 1'b1);
    touch_edge = '0;
    do_clear();

    // start re-pulsed mid-scan is ignored: one done, unchanged latency.
    begin
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      e.crash = '0; e.go = 1'b0; e.s = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (25) @(negedge clk);
      chk("repulse_idle", 32'(busy), 32'd0);
    end

    // Reset in the middle of a scan after a game over.
    set_obj(3, 8'd53, 8'd54);
    run_scan(10'h008, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midscan_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_reset_busy", 32'(busy), 32'd0);
    chk("midscan_reset_crash", 32'(crash), 32'd0);
    chk("midscan_reset_game_over", 32'(game_is_over), 32'd0);
    chk("midscan_reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);

    // clear beats start in the same IDLE cycle.
    run_scan(10'h008, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    chk("clrstart_game_over", 32'(game_is_over), 32'd0);
    chk("clrstart_crash", 32'(crash), 32'd0);
    chk("clrstart_busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);
    chk("clrstart_still_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
